// File: rtl/note_scheduler_if.sv
// Chart ROM read port and judge-facing note window, bundled between scheduler and its neighbours.
interface note_scheduler_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              chart_rd;
  logic [ADDR_W-1:0] chart_addr;
  logic [15:0]       chart_data;
  logic              note_hit;
  logic              note_miss;
  logic [4:0]        notes_to_play;
  logic              window_open;

  modport master (
    output chart_rd, chart_addr, notes_to_play, window_open,
    input  chart_data, note_hit, note_miss
  );

  modport slave (
    input  chart_rd, chart_addr, notes_to_play, window_open,
    output chart_data, note_hit, note_miss
  );
endinterface

// File: rtl/note_scheduler.sv
// Walks a song chart from ROM, opens timed hit windows for the judge and keeps
// score, streak and miss totals.
module note_scheduler #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned WINDOW_TICKS = 150
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  note_scheduler_if.master   bus,
  output logic               song_done,
  output logic [15:0]        score,
  output logic [7:0]         streak,
  output logic [7:0]         miss_count
);
  localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WCNT_W  = $clog2(WINDOW_TICKS + 1);
  localparam int unsigned DELTA_W = 11;
  localparam int unsigned MASK_W  = 5;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [DELTA_W-1:0]  r_dcnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [MASK_W-1:0]   r_mask;
  logic                r_chart_rd;
  logic [ADDR_W-1:0]   r_chart_addr;
  logic [MASK_W-1:0]   r_notes;
  logic                r_window_open;
  logic                r_song_done;
  logic [15:0]         r_score;
  logic [7:0]          r_streak;
  logic [7:0]          r_miss;
  logic                r_pend_hit;
  logic                r_pend_miss;

  logic w_tick;
  logic w_start_song;
  logic w_pend;
  logic w_judge_any;
  logic w_judge_miss;
  logic w_close;
  logic w_close_miss;
  logic w_slot_ready;

  assign w_tick       = !pause && (r_div == DIV_W'(TICK_DIV - 1));
  assign w_start_song = !stop && start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // A judgement taken during pause is parked and applied on the first unpaused cycle.
  assign w_pend       = r_pend_hit | r_pend_miss;
  assign w_judge_any  = w_pend | bus.note_hit | bus.note_miss;
  assign w_judge_miss = w_pend ? r_pend_miss : bus.note_miss;
  assign w_close      = r_window_open && !pause && (w_judge_any || (r_wcnt == '0));
  assign w_close_miss = w_judge_any ? w_judge_miss : 1'b1;
  assign w_slot_ready = (r_state == S_WAIT) && !pause && (r_dcnt == '0) && !r_window_open;

  // Game tick divider, realigned at song start so chart timing is phase-exact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
    end else if (w_start_song) begin
      r_div <= '0;
    end else if (!pause) begin
      r_div <= (r_div == DIV_W'(TICK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_dcnt        <= '0;
      r_wcnt        <= '0;
      r_mask        <= '0;
      r_chart_rd    <= 1'b0;
      r_chart_addr  <= '0;
      r_notes       <= '0;
      r_window_open <= 1'b0;
      r_song_done   <= 1'b0;
      r_score       <= '0;
      r_streak      <= '0;
      r_miss        <= '0;
      r_pend_hit    <= 1'b0;
      r_pend_miss   <= 1'b0;
    end else if (stop) begin
      r_state       <= S_IDLE;
      r_chart_rd    <= 1'b0;
      r_notes       <= '0;
      r_window_open <= 1'b0;
      r_song_done   <= 1'b0;
      r_pend_hit    <= 1'b0;
      r_pend_miss   <= 1'b0;
    end else begin
      r_chart_rd <= 1'b0;

      if (w_close) begin
        r_window_open <= 1'b0;
        r_notes       <= '0;
        r_pend_hit    <= 1'b0;
        r_pend_miss   <= 1'b0;
        if (w_close_miss) begin
          r_miss   <= (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;
          r_streak <= '0;
        end else begin
          r_score  <= (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
          r_streak <= (r_streak == 8'hFF) ? r_streak : r_streak + 8'd1;
        end
      end else if (r_window_open) begin
        if (pause && !w_pend && (bus.note_hit || bus.note_miss)) begin
          r_pend_hit  <= bus.note_hit & ~bus.note_miss;
          r_pend_miss <= bus.note_miss;
        end
        if (w_tick && (r_wcnt != '0)) r_wcnt <= r_wcnt - WCNT_W'(1);
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_FETCH;
            r_chart_addr <= '0;
            r_chart_rd   <= 1'b1;
            r_song_done  <= 1'b0;
            r_score      <= '0;
            r_streak     <= '0;
            r_miss       <= '0;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_mask  <= bus.chart_data[15:11];
          r_dcnt  <= bus.chart_data[10:0];
          r_state <= (bus.chart_data == 16'h0000) ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // A due entry waits for the previous window to close; it is late, never dropped.
          if (w_slot_ready) begin
            if (r_mask != '0) begin
              r_window_open <= 1'b1;
              r_notes       <= r_mask;
              r_wcnt        <= WCNT_W'(WINDOW_TICKS);
            end
            r_chart_addr <= r_chart_addr + ADDR_W'(1);
            r_chart_rd   <= 1'b1;
            r_state      <= S_FETCH;
          end else if (w_tick && (r_dcnt != '0)) begin
            r_dcnt <= r_dcnt - DELTA_W'(1);
          end
        end
        S_DRAIN: begin
          if (!r_window_open) begin
            r_state     <= S_DONE;
            r_song_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.chart_rd      = r_chart_rd;
  assign bus.chart_addr    = r_chart_addr;
  assign bus.notes_to_play = r_notes;
  assign bus.window_open   = r_window_open;
  assign song_done         = r_song_done;
  assign score             = r_score;
  assign streak            = r_streak;
  assign miss_count        = r_miss;
endmodule
